// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, FSM encoding, S-box, RCON, RotWord.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXPAND = 2'b01,
        DONE   = 2'b10
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Link between the key loader / encryption core and the key expander.
interface aes_key_expand_if;

    logic         key_load;
    logic [127:0] key_in;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         busy;
    logic         key_ready;

    modport master (
        output key_load, key_in, round,
        input  round_key, busy, key_ready
    );

    modport slave (
        input  key_load, key_in, round,
        output round_key, busy, key_ready
    );

endinterface

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub = {sbox(word[31:24]), sbox(word[23:16]),
                  sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 round-key expander: one round key per clock into an 11-entry bank.
module aes_key_expand
    import aes_pkg::*;
(
    input logic              clk,
    input logic              rst,
    aes_key_expand_if.slave  kx
);

    localparam logic [3:0] LAST = 4'(NR);

    state_t       state, state_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic         load_en, step_en;
    logic [127:0] bank [0:NR];
    logic [127:0] prev, fresh;
    logic [31:0]  rot, sub, t;
    logic [31:0]  k0, k1, k2, k3;

    assign prev = bank[cnt - 4'd1];
    assign rot  = rot_word(prev[31:0]);

    aes_sub_word u_sub (
        .word (rot),
        .sub  (sub)
    );

    assign t     = sub ^ {rcon(cnt), 24'h0};
    assign k0    = prev[127:96] ^ t;
    assign k1    = prev[95:64]  ^ k0;
    assign k2    = prev[63:32]  ^ k1;
    assign k3    = prev[31:0]   ^ k2;
    assign fresh = {k0, k1, k2, k3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_en   = 1'b0;
        step_en   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (kx.key_load) begin
                    state_nxt = EXPAND;
                    cnt_nxt   = 4'd1;
                    load_en   = 1'b1;
                end
            end
            EXPAND: begin
                step_en = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
                else             cnt_nxt   = cnt + 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) bank[i] <= '0;
        end else if (load_en) begin
            bank[0] <= kx.key_in;
        end else if (step_en) begin
            bank[cnt] <= fresh;
        end
    end

    // Bank read ignores state; the consumer gates on key_ready.
    assign kx.round_key = (kx.round <= LAST) ? bank[kx.round] : '0;
    assign kx.busy      = (state == EXPAND);
    assign kx.key_ready = (state == DONE);

endmodule
